edge_detect_mc: RTL and testbench
=================================

EDGE_DETECT_MC -- requirements
Module: edge_detect_mc

Interface
REQ-001 Parameter CH, default 4: number of independent input channels, range 1..32.
REQ-002 Parameter PULSE_LEN, default 1: stretched-output length in cycles, range 1..255.
REQ-003 Parameter CNT_W, default 8: per-channel event-counter width, range 1..16.
REQ-004 Port clk  input  1: single clock; all logic on its rising edge.
REQ-005 Port rst  input  1: synchronous, active-high reset.
REQ-006 Port din  input  CH: sampled level inputs, already synchronous to clk; bit i is channel i.
REQ-007 Port mode  input  2*CH: per-channel detect mode, bits [2i+1:2i]; 00 off, 01 rising, 10 falling, 11 both.
REQ-008 Port clr  input  CH: per-channel synchronous clear of the event counter.
REQ-009 Port dout  output  CH: one-cycle Moore pulse per qualified edge.
REQ-010 Port dout_str  output  CH: pulse stretched to PULSE_LEN cycles.
REQ-011 Port cnt  output  CH*CNT_W: per-channel saturating event counts, channel i at [CNT_W*i +: CNT_W].

Function
REQ-012 Each channel SHALL run an independent 4-state Moore FSM: S_LO, S_RISE, S_HI, S_FALL.
REQ-013 Transitions SHALL be: S_LO: din=1 -> S_RISE, else S_LO; S_RISE: din=1 -> S_HI, else S_FALL; S_HI: din=1 -> S_HI, else S_FALL; S_FALL: din=1 -> S_RISE, else S_LO.
REQ-014 dout[i] SHALL be (state==S_RISE & mode[2i]) | (state==S_FALL & mode[2i+1]).
REQ-015 Latency: din change sampled at edge k SHALL produce dout high for exactly the cycle after edge k, that is, one clock of latency.
REQ-016 A 1-cycle din glitch (0,1,0) SHALL produce a rising pulse followed directly by a falling pulse; back-to-back edges are never merged.
REQ-017 mode is quasi-static; a change SHALL take effect on the same cycle's dout with no state disturbance; mode 00 suppresses all outputs, but the FSM keeps tracking din.
REQ-018 dout_str[i] SHALL be dout[i] | (str_cnt[i]!=0); str_cnt loads PULSE_LEN-1 on each dout cycle, else decrements to 0; a retrigger restarts the full length.
REQ-019 With PULSE_LEN=1, dout_str SHALL equal dout.
REQ-020 cnt[i] SHALL increment by 1 on each dout[i] cycle and saturate at 2^CNT_W-1, with no wrap.
REQ-021 clr[i] SHALL set cnt[i] to 0 on the next edge; simultaneous clr[i] and dout[i] SHALL set cnt[i] to 1, so the event is not lost.
REQ-022 Channels SHALL not interact; simultaneous edges on all channels are each counted.

Reset
REQ-023 rst=1 SHALL force every channel to S_LO, str_cnt to 0, and cnt to 0; dout, dout_str and cnt read 0 in the cycle after reset.
REQ-024 rst SHALL override din, clr and pulses in progress; mid-stretch reset truncates dout_str.
REQ-025 After reset release, din=1 on the first sampled edge SHALL be reported as a rising edge, because the reset state is S_LO.

Structure
REQ-026 Package edge_detect_pkg SHALL hold the state encoding (S_LO=0, S_RISE=1, S_HI=2, S_FALL=3) and the mode constants (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH).
REQ-027 Sub-module edge_detect_ch SHALL implement one channel (FSM, stretch counter, event counter); the top generates CH instances and packs the vectors.
REQ-028 Counter widths SHALL be $clog2(PULSE_LEN) (minimum 1) and CNT_W; no combinational path from din to any output.

Verification
REQ-029 CH=4, mode=all 01, din[0] 0->1 at cycle 10 -> dout[0]=1 only in cycle 11, cnt[0]=1, other channels 0.
REQ-030 mode[1:0]=11, din[0] pattern 0,1,0 -> dout[0] pulses in two consecutive cycles, cnt[0]=2; mode=10 gives a single pulse on the falling edge only.
REQ-031 PULSE_LEN=4, rising edge, then a second edge 2 cycles later -> dout_str high for 6 consecutive cycles.
REQ-032 CNT_W=2, 5 rising edges -> cnt saturates at 3; clr coincident with a 6th edge -> cnt=1.
REQ-033 rst asserted mid-stretch with din=1 held, then released -> all outputs 0 during reset, then a rising pulse in the 2nd cycle after release.
REQ-034 mode=00 with din toggling, then mode switched to 01 while din stays high -> no pulses; the next 0->1 is detected normally.

Source files
------------

// File: rtl/edge_detect_pkg.sv
// Shared definitions for the multi-channel edge detector: channel FSM
// encoding, per-channel mode codes and a width helper for the stretch counter.
package edge_detect_pkg;

    typedef enum logic [1:0] {
        S_LO   = 2'd0,
        S_RISE = 2'd1,
        S_HI   = 2'd2,
        S_FALL = 2'd3
    } state_t;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // A PULSE_LEN of 1 needs no stretch state, but a zero-width vector is
    // illegal, so the counter is never narrower than one bit.
    function automatic int str_width(input int pulse_len);
        int w;
        w = $clog2(pulse_len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/edge_detect_ch.sv
// One edge-detect channel: 4-state Moore FSM tracking the input level, a
// pulse stretcher and a saturating event counter with synchronous clear.
module edge_detect_ch
    import edge_detect_pkg::*;
#(
    parameter int PULSE_LEN = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic [1:0]       mode,
    input  logic             clr,
    output logic             dout,
    output logic             dout_str,
    output logic [CNT_W-1:0] cnt
);

    localparam int               STR_W    = str_width(PULSE_LEN);
    localparam logic [STR_W-1:0] STR_LOAD = STR_W'(PULSE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [STR_W-1:0] str_cnt_reg, str_cnt_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             pulse;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_LO;
            str_cnt_reg <= '0;
            cnt_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            str_cnt_reg <= str_cnt_next;
            cnt_reg     <= cnt_next;
        end
    end

    // Mode only gates the Moore output, so changing it never disturbs tracking.
    always_comb begin
        pulse = ((state_reg == S_RISE) && mode[0]) ||
                ((state_reg == S_FALL) && mode[1]);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_LO:    state_next = din ? S_RISE : S_LO;
            S_RISE:  state_next = din ? S_HI   : S_FALL;
            S_HI:    state_next = din ? S_HI   : S_FALL;
            S_FALL:  state_next = din ? S_RISE : S_LO;
            default: state_next = S_LO;
        endcase
    end

    always_comb begin
        str_cnt_next = str_cnt_reg;
        if (pulse) begin
            str_cnt_next = STR_LOAD;
        end else if (str_cnt_reg != '0) begin
            str_cnt_next = str_cnt_reg - STR_W'(1);
        end
    end

    // A clear that lands on a pulse cycle keeps that event as the first count.
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = pulse ? CNT_ONE : '0;
        end else if (pulse && (cnt_reg != CNT_MAX)) begin
            cnt_next = cnt_reg + CNT_ONE;
        end
    end

    assign dout     = pulse;
    assign dout_str = pulse || (str_cnt_reg != '0);
    assign cnt      = cnt_reg;

endmodule

// File: rtl/edge_detect_mc.sv
// Multi-channel edge detector: CH independent channels, packed into flat
// din/mode/clr/dout/dout_str/cnt vectors.
module edge_detect_mc #(
    parameter int CH        = 4,
    parameter int PULSE_LEN = 1,
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CH-1:0]       din,
    input  logic [2*CH-1:0]     mode,
    input  logic [CH-1:0]       clr,
    output logic [CH-1:0]       dout,
    output logic [CH-1:0]       dout_str,
    output logic [CH*CNT_W-1:0] cnt
);

    generate
        for (genvar gi = 0; gi < CH; gi++) begin : g_ch
            edge_detect_ch #(
                .PULSE_LEN (PULSE_LEN),
                .CNT_W     (CNT_W)
            ) u_ch (
                .clk      (clk),
                .rst      (rst),
                .din      (din[gi]),
                .mode     (mode[2*gi +: 2]),
                .clr      (clr[gi]),
                .dout     (dout[gi]),
                .dout_str (dout_str[gi]),
                .cnt      (cnt[CNT_W*gi +: CNT_W])
            );
        end
    endgenerate

endmodule

// File: tb/tb_edge_detect_mc.sv
// Self-checking bench for edge_detect_mc: two configurations driven in parallel,
// a vector table, directed corner sequences and a random run against a level-history model.
module tb_edge_detect_mc;
    import edge_detect_pkg::*;

    localparam int CH   = 4;
    localparam int PL_A = 1;
    localparam int CW_A = 8;
    localparam int PL_B = 4;
    localparam int CW_B = 2;
    localparam int FAR  = 1000;

    logic                 clk = 1'b0;
    logic                 rst_r;
    logic [CH-1:0]        din_r;
    logic [2*CH-1:0]      mode_r;
    logic [CH-1:0]        clr_r;
    logic [CH-1:0]        dout_a, dout_str_a, dout_b, dout_str_b;
    logic [CH*CW_A-1:0]   cnt_a;
    logic [CH*CW_B-1:0]   cnt_b;

    always #5 clk = ~clk;

    edge_detect_mc #(.CH(CH), .PULSE_LEN(PL_A), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst(rst_r), .din(din_r), .mode(mode_r), .clr(clr_r),
        .dout(dout_a), .dout_str(dout_str_a), .cnt(cnt_a)
    );

    edge_detect_mc #(.CH(CH), .PULSE_LEN(PL_B), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst_r), .din(din_r), .mode(mode_r), .clr(clr_r),
        .dout(dout_b), .dout_str(dout_str_b), .cnt(cnt_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Model: level history per channel; an edge is a difference between the
    // last two sampled levels, stretch is "cycles since the last pulse".
    int prev_m  [CH];
    bit rose_m  [CH];
    bit fell_m  [CH];
    int since_a [CH];
    int since_b [CH];
    int cnt_a_m [CH];
    int cnt_b_m [CH];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic bit pulse_of(input int i);
        return (rose_m[i] && mode_r[2*i]) || (fell_m[i] && mode_r[2*i+1]);
    endfunction

    function automatic int bump(input int c, input bit p, input bit clr, input int w);
        int mx;
        mx = (1 << w) - 1;
        if (clr) return p ? 1 : 0;
        if (p) return (c + 1 > mx) ? mx : c + 1;
        return c;
    endfunction

    task automatic model_edge();
        bit p;
        for (int i = 0; i < CH; i++) begin
            p = pulse_of(i);
            if (rst_r) begin
                since_a[i] = FAR; since_b[i] = FAR;
                cnt_a_m[i] = 0;   cnt_b_m[i] = 0;
                prev_m[i]  = 0;   rose_m[i]  = 0; fell_m[i] = 0;
            end else begin
                since_a[i] = p ? 1 : ((since_a[i] < FAR) ? since_a[i] + 1 : FAR);
                since_b[i] = p ? 1 : ((since_b[i] < FAR) ? since_b[i] + 1 : FAR);
                cnt_a_m[i] = bump(cnt_a_m[i], p, clr_r[i], CW_A);
                cnt_b_m[i] = bump(cnt_b_m[i], p, clr_r[i], CW_B);
                rose_m[i]  = (din_r[i] == 1'b1) && (prev_m[i] == 0);
                fell_m[i]  = (din_r[i] == 1'b0) && (prev_m[i] == 1);
                prev_m[i]  = din_r[i] ? 1 : 0;
            end
        end
    endtask

    task automatic model_check();
        logic [CH-1:0]      ed, esa, esb;
        logic [CH*CW_A-1:0] eca;
        logic [CH*CW_B-1:0] ecb;
        for (int i = 0; i < CH; i++) begin
            ed[i]  = pulse_of(i);
            esa[i] = ed[i] || (since_a[i] < PL_A);
            esb[i] = ed[i] || (since_b[i] < PL_B);
            eca[CW_A*i +: CW_A] = CW_A'(cnt_a_m[i]);
            ecb[CW_B*i +: CW_B] = CW_B'(cnt_b_m[i]);
        end
        check("model_dout_a", dout_a, ed);
        check("model_str_a",  dout_str_a, esa);
        check("model_cnt_a",  cnt_a, eca);
        check("model_dout_b", dout_b, ed);
        check("model_str_b",  dout_str_b, esb);
        check("model_cnt_b",  cnt_b, ecb);
    endtask

    task automatic tick(input logic r, input logic [CH-1:0] d,
                        input logic [2*CH-1:0] m, input logic [CH-1:0] c);
        rst_r = r; din_r = d; mode_r = m; clr_r = c;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    typedef struct packed {
        logic            rst;
        logic [CH-1:0]   din;
        logic [2*CH-1:0] mode;
        logic [CH-1:0]   clr;
        logic [CH-1:0]   exp_dout;
        logic [CH-1:0]   exp_str_b;
        logic [7:0]      exp_cnt0;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [2*CH-1:0] m_rise, m_off;
        logic [2*CH-1:0] m_rnd;
        logic [CH-1:0]   d_rnd, c_rnd;
        int run;
        int pat [8];

        m_rise = {CH{MODE_RISE}};
        m_off  = {CH{MODE_OFF}};
        rst_r = 1'b1; din_r = '0; mode_r = m_rise; clr_r = '0;
        for (int i = 0; i < CH; i++) begin
            prev_m[i] = 0; rose_m[i] = 0; fell_m[i] = 0;
            since_a[i] = FAR; since_b[i] = FAR; cnt_a_m[i] = 0; cnt_b_m[i] = 0;
        end

        //            rst   din    mode   clr   dout  str_b cnt0_a
        vecs[0]  = '{1'b1, 4'h0, 8'h55, 4'h0, 4'h0, 4'h0, 8'd0};
        vecs[1]  = '{1'b0, 4'h0, 8'h55, 4'h0, 4'h0, 4'h0, 8'd0};
        vecs[2]  = '{1'b0, 4'h1, 8'h55, 4'h0, 4'h1, 4'h1, 8'd0};
        vecs[3]  = '{1'b0, 4'h1, 8'h55, 4'h0, 4'h0, 4'h1, 8'd1};
        vecs[4]  = '{1'b0, 4'h1, 8'h55, 4'h0, 4'h0, 4'h1, 8'd1};
        vecs[5]  = '{1'b0, 4'h1, 8'h55, 4'h0, 4'h0, 4'h1, 8'd1};
        vecs[6]  = '{1'b0, 4'h1, 8'h55, 4'h0, 4'h0, 4'h0, 8'd1};
        vecs[7]  = '{1'b0, 4'h0, 8'h57, 4'h0, 4'h1, 4'h1, 8'd1};
        vecs[8]  = '{1'b0, 4'h0, 8'h57, 4'h0, 4'h0, 4'h1, 8'd2};
        vecs[9]  = '{1'b0, 4'h0, 8'h57, 4'h0, 4'h0, 4'h1, 8'd2};
        vecs[10] = '{1'b0, 4'h1, 8'h57, 4'h0, 4'h1, 4'h1, 8'd2};
        vecs[11] = '{1'b0, 4'h0, 8'h57, 4'h0, 4'h1, 4'h1, 8'd3};
        vecs[12] = '{1'b0, 4'h0, 8'h57, 4'h0, 4'h0, 4'h1, 8'd4};
        vecs[13] = '{1'b0, 4'h1, 8'h56, 4'h0, 4'h0, 4'h1, 8'd4};
        vecs[14] = '{1'b0, 4'h0, 8'h56, 4'h0, 4'h1, 4'h1, 8'd4};
        vecs[15] = '{1'b0, 4'h0, 8'h56, 4'h0, 4'h0, 4'h1, 8'd5};
        vecs[16] = '{1'b0, 4'hF, 8'h56, 4'h0, 4'hE, 4'hF, 8'd5};
        vecs[17] = '{1'b0, 4'hF, 8'h56, 4'h0, 4'h0, 4'hF, 8'd5};
        vecs[18] = '{1'b0, 4'hF, 8'h56, 4'h0, 4'h0, 4'hE, 8'd5};
        vecs[19] = '{1'b0, 4'hF, 8'h56, 4'h1, 4'h0, 4'hE, 8'd0};
        vecs[20] = '{1'b0, 4'hF, 8'h56, 4'h0, 4'h0, 4'h0, 8'd0};

        for (int v = 0; v < NV; v++) begin
            tick(vecs[v].rst, vecs[v].din, vecs[v].mode, vecs[v].clr);
            check("vec_dout",  dout_a, vecs[v].exp_dout);
            check("vec_str_a", dout_str_a, dout_a);
            check("vec_str_b", dout_str_b, vecs[v].exp_str_b);
            check("vec_cnt0",  cnt_a[7:0], vecs[v].exp_cnt0);
            $display("vec %0d rst=%0b din=%h mode=%h clr=%h -> dout=%h str_b=%h cnt0=%0d",
                     v, vecs[v].rst, vecs[v].din, vecs[v].mode, vecs[v].clr,
                     dout_a, dout_str_b, cnt_a[7:0]);
        end

        // Stretch: rising edge, second rising edge two cycles later, PULSE_LEN=4.
        tick(1'b1, 4'h0, m_rise, 4'h0);
        pat = '{1, 0, 1, 0, 0, 0, 0, 0};
        run = 0;
        for (int k = 0; k < 8; k++) begin
            tick(1'b0, pat[k] ? 4'h1 : 4'h0, m_rise, 4'h0);
            if (dout_str_b[0]) run++;
        end
        check("stretch_len", 64'(run), 64'd6);
        $display("seq stretch: dout_str high for %0d cycles", run);

        // Saturation of the 2-bit counter, then clear coincident with a pulse.
        tick(1'b1, 4'h0, m_rise, 4'h0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, 4'h1, m_rise, 4'h0);
            tick(1'b0, 4'h0, m_rise, 4'h0);
        end
        check("sat_cnt", 64'(cnt_b[1:0]), 64'd3);
        tick(1'b0, 4'h1, m_rise, 4'h0);
        check("sat_6th_pulse", 64'(dout_b[0]), 64'd1);
        tick(1'b0, 4'h0, m_rise, 4'h1);
        check("clr_with_pulse", 64'(cnt_b[1:0]), 64'd1);
        $display("seq saturate: cnt_b[0] after clr+pulse = %0d", cnt_b[1:0]);

        // Reset mid-stretch with din held high.
        tick(1'b1, 4'h0, m_rise, 4'h0);
        tick(1'b0, 4'h1, m_rise, 4'h0);
        check("pre_rst_pulse", 64'(dout_b), 64'h1);
        tick(1'b1, 4'h1, m_rise, 4'h0);
        check("rst_dout", 64'(dout_b), 64'h0);
        check("rst_str",  64'(dout_str_b), 64'h0);
        check("rst_cnt",  64'(cnt_b), 64'h0);
        tick(1'b0, 4'h1, m_rise, 4'h0);
        check("post_rst_rise", 64'(dout_b), 64'h1);
        tick(1'b0, 4'h1, m_rise, 4'h0);
        check("post_rst_quiet", 64'(dout_b), 64'h0);
        $display("seq reset: rising pulse reported after release");

        // Mode off while toggling, then enable with din held high.
        tick(1'b1, 4'h0, m_off, 4'h0);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0, (k % 2 == 0) ? 4'hF : 4'h0, m_off, 4'h0);
            check("off_dout", 64'(dout_a), 64'h0);
            check("off_str",  64'(dout_str_b), 64'h0);
        end
        tick(1'b0, 4'hF, m_rise, 4'h0);
        check("enable_high_no_pulse", 64'(dout_a), 64'h0);
        tick(1'b0, 4'h0, m_rise, 4'h0);
        check("enable_fall_no_pulse", 64'(dout_a), 64'h0);
        tick(1'b0, 4'hF, m_rise, 4'h0);
        check("enable_next_rise", 64'(dout_a), 64'hF);
        $display("seq mode_off: next rise detected on all channels");

        // Random run with clears, resets and mode changes.
        m_rnd = m_rise;
        d_rnd = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 2) == 0) d_rnd[i] = ~d_rnd[i];
            if ($urandom_range(0, 49) == 0) m_rnd = 8'($urandom);
            for (int i = 0; i < CH; i++) c_rnd[i] = ($urandom_range(0, 15) == 0);
            tick($urandom_range(0, 199) == 0, d_rnd, m_rnd, c_rnd);
        end
        $display("random phase 1 done: %0d/%0d so far", n_pass, n_total);

        // Long run in both-edge mode so the 8-bit counters reach saturation.
        tick(1'b1, 4'h0, {CH{MODE_BOTH}}, 4'h0);
        d_rnd = '0;
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < CH; i++)
                if ($urandom_range(0, 1) == 0) d_rnd[i] = ~d_rnd[i];
            tick(1'b0, d_rnd, {CH{MODE_BOTH}}, 4'h0);
        end
        check("sat_cnt_a", 64'(cnt_a), 64'hFFFF_FFFF);
        $display("random phase 2 done: cnt_a=%h", cnt_a);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
